lsu: RTL and testbench

Load/store unit: the initiator side of the data-memory port. Accepts one load or store request at a time from the execute stage, with a 32-bit byte address and RISC-V funct3 width/sign encoding. It drives the word-addressed, 8-bank data memory over `memaddr`/`rw`/`datain` and reads back `dmem`. It performs byte/halfword extraction with sign or zero extension, and read-modify-write for SB/SH, because the memory is word-write only.

---
 rtl/lsu.sv | 176 +++++++++++++++++
 tb/tb_lsu.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: single-outstanding initiator on the word-addressed data memory.
// Handles byte/halfword extraction on loads and read-modify-write for SB/SH.
module lsu #(
    parameter int RD_LAT  = 2,
    parameter int WR_HOLD = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [12:0] memaddr,
    output logic        rw,
    output logic [31:0] datain,
    input  logic [31:0] dmem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [7:0] RD_LAST = 8'(RD_LAT - 1);
    localparam logic [7:0] WR_LAST = 8'(WR_HOLD - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  cnt_r;
    logic [1:0]  addr_lo_r;
    logic [15:0] wdata_lo_r;
    logic [2:0]  f3_r;
    logic        we_r;
    logic        accept_s;
    logic        req_err_s;

    // Misaligned, out-of-range or illegal-funct3 detection for an incoming request
    function automatic logic chk_err(input logic [31:0] a, input logic [2:0] f3, input logic we);
        logic e;
        e = (a[31:15] != 17'd0);
        case (f3)
            3'd0:    e = e;
            3'd1:    e = e | a[0];
            3'd2:    e = e | (a[1:0] != 2'd0);
            3'd4:    e = e | we;
            3'd5:    e = e | we | a[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd4:    r = {24'd0, b};
            3'd5:    r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] a,
                                                input logic [2:0] f3, input logic [15:0] d);
        logic [31:0] r;
        r = w;
        if (f3 == 3'd0) begin
            r[{a, 3'b000} +: 8] = d[7:0];
        end else if (f3 == 3'd1) begin
            if (a[1]) r[31:16] = d;
            else      r[15:0]  = d;
        end else begin
            r = w;
        end
        return r;
    endfunction

    assign req_ready = (state_r == IDLE);
    assign accept_s  = req_valid & req_ready;
    assign req_err_s = chk_err(req_addr, req_funct3, req_we);

    // Next-state selection
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (req_err_s)                           state_nxt_s = ERR;
                    else if (req_we && req_funct3 == 3'd2)   state_nxt_s = WR;
                    else                                     state_nxt_s = RD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD: begin
                if (cnt_r == RD_LAST) state_nxt_s = we_r ? WR : IDLE;
                else                  state_nxt_s = RD;
            end
            WR: begin
                if (cnt_r == WR_LAST) state_nxt_s = IDLE;
                else                  state_nxt_s = WR;
            end
            ERR:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, capture, memory-port and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= 8'd0;
            addr_lo_r  <= 2'd0;
            wdata_lo_r <= 16'd0;
            f3_r       <= 3'd0;
            we_r       <= 1'b0;
            memaddr    <= 13'd0;
            rw         <= 1'b0;
            datain     <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= (state_nxt_s != state_r) ? 8'd0 : (cnt_r + 8'd1);
            rw         <= (state_nxt_s == WR);
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_lo_r  <= req_addr[1:0];
                        wdata_lo_r <= req_wdata[15:0];
                        f3_r       <= req_funct3;
                        we_r       <= req_we;
                        // Errored requests never touch the memory port
                        if (!req_err_s) memaddr <= req_addr[14:2];
                        if (!req_err_s && req_we && req_funct3 == 3'd2) datain <= req_wdata;
                    end
                end
                RD: begin
                    if (cnt_r == RD_LAST) begin
                        if (we_r) begin
                            datain <= store_merge(dmem, addr_lo_r, f3_r, wdata_lo_r);
                        end else begin
                            resp_valid <= 1'b1;
                            resp_rdata <= load_ext(dmem, addr_lo_r, f3_r);
                        end
                    end
                end
                WR: begin
                    if (cnt_r == WR_LAST) resp_valid <= 1'b1;
                end
                ERR: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b1;
                end
                default: resp_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a behavioural word memory and a response scoreboard.
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [12:0] memaddr;
    logic        rw;
    logic [31:0] datain;
    logic [31:0] dmem;

    logic [31:0] mem [0:8191];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    lsu #(.RD_LAT(2), .WR_HOLD(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .memaddr(memaddr), .rw(rw), .datain(datain), .dmem(dmem)
    );

    always #5 clk = ~clk;

    // Word memory: combinational read, write on the clock edge while rw is high
    always @(posedge clk) begin
        if (rw) mem[memaddr] <= datain;
    end
    assign dmem = mem[memaddr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge, then follow it to its response
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input int exp_wr, input logic [31:0] exp_datain);
        exp_t        e;
        exp_t        got;
        logic [12:0] ma_before;
        logic [12:0] wr_addr;
        logic [31:0] wr_data;
        int          wr_cnt;
        int          lat;
        bit          done;
        @(negedge clk);
        check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        ma_before  = memaddr;
        e.rdata    = exp_rdata;
        e.err      = exp_err;
        e.lat      = exp_lat;
        sb.push_back(e);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        wr_cnt  = 0;
        wr_addr = 13'd0;
        wr_data = 32'd0;
        lat     = 0;
        done    = 1'b0;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rw) begin
                if (wr_cnt == 0) begin
                    wr_addr = memaddr;
                    wr_data = datain;
                end
                wr_cnt++;
            end
            if (resp_valid) begin
                lat  = k;
                done = 1'b1;
            end
        end
        check({tag, ".responded"}, {31'd0, done}, 32'd1);
        if (done) begin
            check({tag, ".sb_nonempty"}, (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() > 0) begin
                got = sb.pop_front();
                check({tag, ".rdata"}, resp_rdata, got.rdata);
                check({tag, ".err"}, {31'd0, resp_err}, {31'd0, got.err});
                check({tag, ".latency"}, lat, got.lat);
            end
        end
        check({tag, ".rw_cycles"}, wr_cnt, exp_wr);
        if (exp_wr > 0) begin
            check({tag, ".wr_memaddr"}, {19'd0, wr_addr}, {19'd0, addr[14:2]});
            check({tag, ".wr_datain"}, wr_data, exp_datain);
        end
        if (exp_err) check({tag, ".memaddr_kept"}, {19'd0, memaddr}, {19'd0, ma_before});
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (3) @(posedge clk);
        // Request during reset must be ignored
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_funct3 = 3'd2;
        req_addr  = 32'h0000_0010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst.memaddr", {19'd0, memaddr}, 32'd0);
        check("rst.rw", {31'd0, rw}, 32'd0);
        check("rst.datain", datain, 32'd0);
        check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.resp_err", {31'd0, resp_err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst.ready_after", {31'd0, req_ready}, 32'd1);
        check("rst.no_write", {31'd0, rw}, 32'd0);

        do_req("sw104",  1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 32'd0,         1'b0, 3, 2, 32'hDEADBEEF);
        do_req("lw104",  1'b0, 3'd2, 32'h104, 32'd0,        32'hDEADBEEF,  1'b0, 3, 0, 32'd0);
        do_req("sb105",  1'b1, 3'd0, 32'h105, 32'h000000AA, 32'd0,         1'b0, 5, 2, 32'hDEADAAEF);
        do_req("lb105",  1'b0, 3'd0, 32'h105, 32'd0,        32'hFFFFFFAA,  1'b0, 3, 0, 32'd0);
        do_req("lbu105", 1'b0, 3'd4, 32'h105, 32'd0,        32'h000000AA,  1'b0, 3, 0, 32'd0);
        do_req("sh106",  1'b1, 3'd1, 32'h106, 32'h00001234, 32'd0,         1'b0, 5, 2, 32'h1234AAEF);
        do_req("lh106",  1'b0, 3'd1, 32'h106, 32'd0,        32'h00001234,  1'b0, 3, 0, 32'd0);
        do_req("lhu104", 1'b0, 3'd5, 32'h104, 32'd0,        32'h0000AAEF,  1'b0, 3, 0, 32'd0);
        do_req("lw104b", 1'b0, 3'd2, 32'h104, 32'd0,        32'h1234AAEF,  1'b0, 3, 0, 32'd0);
        do_req("lh102e", 1'b0, 3'd1, 32'h103, 32'd0,        32'd0,         1'b1, 2, 0, 32'd0);
        do_req("lw102e", 1'b0, 3'd2, 32'h102, 32'd0,        32'd0,         1'b1, 2, 0, 32'd0);
        do_req("sw8000e",1'b1, 3'd2, 32'h8000, 32'h55555555, 32'd0,        1'b1, 2, 0, 32'd0);
        do_req("ldf3e",  1'b0, 3'd3, 32'h104, 32'd0,        32'd0,         1'b1, 2, 0, 32'd0);
        do_req("sbf4e",  1'b1, 3'd4, 32'h104, 32'd0,        32'd0,         1'b1, 2, 0, 32'd0);
        do_req("sw7ffc", 1'b1, 3'd2, 32'h7FFC, 32'h11111111, 32'd0,        1'b0, 3, 2, 32'h11111111);
        do_req("sw0",    1'b1, 3'd2, 32'h0,   32'h22222222, 32'd0,         1'b0, 3, 2, 32'h22222222);
        do_req("lw7ffc", 1'b0, 3'd2, 32'h7FFC, 32'd0,       32'h11111111,  1'b0, 3, 0, 32'd0);
        do_req("lw0",    1'b0, 3'd2, 32'h0,   32'd0,        32'h22222222,  1'b0, 3, 0, 32'd0);
        do_req("lb7fff", 1'b0, 3'd0, 32'h7FFF, 32'd0,       32'h00000011,  1'b0, 3, 0, 32'd0);

        // SB aborted by reset in its first write cycle (T+3)
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd0;
        req_addr   = 32'h105;
        req_wdata  = 32'h000000BB;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort.rw_T3", {31'd0, rw}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.rw_T4", {31'd0, rw}, 32'd0);
        check("abort.no_resp_T4", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        check("abort.ready_T5", {31'd0, req_ready}, 32'd1);
        check("abort.no_resp_T5", {31'd0, resp_valid}, 32'd0);
        check("abort.rw_T5", {31'd0, rw}, 32'd0);
        check("abort.sb_empty", sb.size(), 32'd0);

        do_req("lw_after", 1'b0, 3'd2, 32'h7FFC, 32'd0, 32'h11111111, 1'b0, 3, 0, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
